// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-port arbiter slice.
//   - width defaults for address, data and byte-mask buses
//   - arbiter FSM state type
//   - transaction owner type (IFU / LSU)
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant (IFU vs LSU).
//   clk, rst      : clock, synchronous active-high reset (pointer -> IFU)
//   req_ifu/lsu   : request inputs
//   en            : grants may only be issued while en is high
//   accept        : a grant was taken this cycle; move the pointer away
//                   from the side that was served
//   gnt_ifu/lsu   : one-hot (or zero) combinational grant
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic en,
  input  logic accept,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  owner_t ptr;

  always_comb begin
    gnt_ifu = en & req_ifu & (~req_lsu | (ptr == OWN_IFU));
    gnt_lsu = en & req_lsu & (~req_ifu | (ptr == OWN_LSU));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= OWN_IFU;
    end else if (accept) begin
      ptr <= gnt_lsu ? OWN_IFU : OWN_LSU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the IFU and the LSU.
//   clk, rst                 : clock, synchronous active-high reset
//   ifu_req_*/ifu_addr       : IFU read request, ready is the accept strobe
//   ifu_resp_valid/ifu_rdata : one-cycle response pulse + held fetch word
//   lsu_req_*/lsu_*          : LSU load/store request, ready is the accept strobe
//   lsu_resp_valid/lsu_rdata : one-cycle response pulse + held load word
//   mem_req_*/mem_*          : latched request to memory, valid/ready handshake
//   mem_resp_valid/mem_rdata : memory response (only observed while waiting)
//   busy                     : a transaction is in flight
//   owner_lsu                : owner of the current/last transaction
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MASK_W = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_lsu
);

  state_t state, state_next;
  owner_t owner;
  logic   arb_en;

  // No grants while reset is held, so a requester never sees an accept
  // that the reset would immediately discard.
  assign arb_en = (state == ST_IDLE) & ~rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_ifu (ifu_req_valid),
    .req_lsu (lsu_req_valid),
    .en      (arb_en),
    .accept  (ifu_req_ready | lsu_req_ready),
    .gnt_ifu (ifu_req_ready),
    .gnt_lsu (lsu_req_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IFU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      state <= state_next;
      if (lsu_req_ready) begin
        owner     <= OWN_LSU;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
      end else if (ifu_req_ready) begin
        owner     <= OWN_IFU;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end
      if ((state == ST_WAIT) && mem_resp_valid) begin
        if (owner == OWN_LSU) lsu_rdata <= mem_rdata;
        else                  ifu_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next     = state;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    busy           = (state != ST_IDLE);
    owner_lsu      = (owner == OWN_LSU);
    case (state)
      ST_IDLE: begin
        if (ifu_req_ready | lsu_req_ready) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_next = ST_RESP;
      end
      ST_RESP: begin
        ifu_resp_valid = (owner == OWN_IFU);
        lsu_resp_valid = (owner == OWN_LSU);
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter.
// The reference keeps only the round-robin preference, the last word returned
// to each side, and the expected request fields of the transaction in flight.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy, owner_lsu;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference state
  bit          fav_lsu;
  logic [31:0] m_ifu_rdata, m_lsu_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner_lsu(owner_lsu)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_no_resp(input string tag);
    check({tag, "_ifu_resp"}, ifu_resp_valid, 0);
    check({tag, "_lsu_resp"}, lsu_resp_valid, 0);
    check({tag, "_ifu_rdata"}, ifu_rdata, m_ifu_rdata);
    check({tag, "_lsu_rdata"}, lsu_rdata, m_lsu_rdata);
  endtask

  // Called at a negedge (+ settle) with the DUT idle; returns the same way.
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                     input bit lwen, input logic [31:0] lwd, input logic [3:0] lwm,
                     input int unsigned d1, input int unsigned d2, input logic [31:0] rd);
    bit          win_lsu;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_wm;
    bit          e_wen;
    win_lsu = lv && (!iv || fav_lsu);
    e_addr  = win_lsu ? la : ia;
    e_wen   = win_lsu && lwen;
    e_wd    = win_lsu ? lwd : 32'h0;
    e_wm    = win_lsu ? lwm : 4'h0;

    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lwen; lsu_wdata = lwd; lsu_wmask = lwm;
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("ifu_ready", ifu_req_ready, iv && !win_lsu);
    check("lsu_ready", lsu_req_ready, win_lsu);
    check("idle_mem_req_valid", mem_req_valid, 0);
    fav_lsu = !win_lsu;
    step();

    // ISSUE: fields must stay put while requester inputs churn
    for (int unsigned k = 0; k <= d1; k++) begin
      ifu_req_valid = 1'($urandom); lsu_req_valid = 1'($urandom);
      ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wen = 1'($urandom);
      mem_req_ready  = (k == d1);
      mem_resp_valid = (k != d1) && 1'($urandom);
      mem_rdata      = $urandom;
      #1;
      check("issue_valid", mem_req_valid, 1);
      check("issue_addr", mem_addr, e_addr);
      check("issue_wen", mem_wen, e_wen);
      check("issue_wdata", mem_wdata, e_wd);
      check("issue_wmask", mem_wmask, e_wm);
      check("issue_owner", owner_lsu, win_lsu);
      check("issue_busy", busy, 1);
      check("issue_readies", {ifu_req_ready, lsu_req_ready}, 0);
      check_no_resp("issue");
      step();
    end

    // WAIT
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    for (int unsigned k = 0; k < d2; k++) begin
      #1;
      check("wait_valid", mem_req_valid, 0);
      check("wait_busy", busy, 1);
      check("wait_readies", {ifu_req_ready, lsu_req_ready}, 0);
      check_no_resp("wait");
      step();
    end
    mem_resp_valid = 1'b1; mem_rdata = rd;
    #1;
    check_no_resp("wait_resp");
    step();

    // RESP: stray memory response here must be ignored
    mem_resp_valid = 1'($urandom); mem_rdata = $urandom;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    if (win_lsu) m_lsu_rdata = rd; else m_ifu_rdata = rd;
    #1;
    check("resp_ifu_valid", ifu_resp_valid, !win_lsu);
    check("resp_lsu_valid", lsu_resp_valid, win_lsu);
    check("resp_ifu_rdata", ifu_rdata, m_ifu_rdata);
    check("resp_lsu_rdata", lsu_rdata, m_lsu_rdata);
    check("resp_busy", busy, 1);
    step();

    mem_resp_valid = 1'b0;
    #1;
    check("done_busy", busy, 0);
    check_no_resp("done");
  endtask

  task automatic stray_idle();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = $urandom;
    step();
    mem_resp_valid = 1'b0;
    #1;
    check("stray_busy", busy, 0);
    check_no_resp("stray");
  endtask

  task automatic reset_in_wait();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; lsu_req_valid = 1'b0;
    #1;
    check("rst_pre_ready", ifu_req_ready, 1);
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    fav_lsu = 1'b0; m_ifu_rdata = '0; m_lsu_rdata = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_owner", owner_lsu, 0);
    check_no_resp("rst");
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    #1;
    check_no_resp("rst_late");
    check("rst_late_busy", busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    fav_lsu = 0; m_ifu_rdata = 0; m_lsu_rdata = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_req_valid", mem_req_valid, 0);
    check("reset_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
    check("reset_owner", owner_lsu, 0);
    check_no_resp("reset");

    // IFU only fetch
    txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 32'h0010_0073);
    // LSU load so both rdata registers hold something before the reset test
    txn(0, 1, 0, 32'h8000_2000, 0, 0, 0, 1, 2, 32'hcafe_f00d);
    // reset in WAIT, then tie -> IFU, tie -> LSU, tie -> IFU
    reset_in_wait();
    txn(1, 1, 32'h8000_0004, 32'h8000_1000, 0, 0, 0, 0, 0, 32'h1111_1111);
    txn(1, 1, 32'h8000_0004, 32'h8000_1000, 0, 0, 0, 0, 0, 32'h2222_2222);
    txn(1, 1, 32'h8000_0008, 32'h8000_1000, 0, 0, 0, 0, 0, 32'h3333_3333);
    // store with memory stalling for 3 cycles
    txn(0, 1, 0, 32'h8000_1000, 1, 32'hdead_beef, 4'b0011, 3, 1, 32'h0);
    stray_idle();
    // back-to-back zero-wait fetches
    for (int unsigned i = 0; i < 4; i++)
      txn(1, 0, 32'h8000_0100 + 4 * i, 0, 0, 0, 0, 0, 0, $urandom);

    for (int unsigned i = 0; i < 200; i++) begin
      bit iv, lv;
      iv = 1'($urandom); lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      txn(iv, lv, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 7) == 0) stray_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
